// File: rtl/mac_tap_sequencer_pkg.sv
// rtl/mac_tap_sequencer_pkg.sv - shared types and width helper for the MAC tap sequencer
// Purpose: holds the sequencer state encoding and the tap-counter width function.
// Ports: none (package).
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Width of the tap counter / k_addr; a one-tap job still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_tap_sequencer_if.sv
// rtl/mac_tap_sequencer_if.sv - operand and result handshake bundle for the MAC tap sequencer
// Purpose: groups the operand-pair stream handshake (s_*) and the result handshake (m_*).
// Ports (signals):
//   s_TVALID  source -> sequencer  operand pair valid
//   s_TREADY  sequencer -> source  operand pair accepted this cycle
//   m_TVALID  sequencer -> consumer  accumulator holds the final job sum
//   m_TREADY  consumer -> sequencer  result taken
// Modports: master = source/consumer side, slave = sequencer side.
interface mac_seq_if;

  logic s_TVALID;
  logic s_TREADY;
  logic m_TVALID;
  logic m_TREADY;

  modport master (
    output s_TVALID,
    output m_TREADY,
    input  s_TREADY,
    input  m_TVALID
  );

  modport slave (
    input  s_TVALID,
    input  m_TREADY,
    output s_TREADY,
    output m_TVALID
  );

endinterface

// File: rtl/mac_tap_sequencer_tap_ctr.sv
// rtl/mac_tap_sequencer_tap_ctr.sv - tap counter with terminal flag for the MAC tap sequencer
// Purpose: counts accepted taps of the current job and flags the last tap (N_TAPS-1).
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-low reset
//   clear  in   return count to 0
//   inc    in   advance to the next tap
//   count  out  current tap index
//   last   out  count == N_TAPS-1
module mac_seq_tap_ctr #(
  parameter int N_TAPS = 9,
  parameter int CNT_W  = mac_seq_pkg::cnt_w(N_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TAPS - 1);

  assign last = (count == LAST_IDX);

  // The count stops at the last tap instead of wrapping, so a power-of-two
  // N_TAPS never needs an extra counter bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_tap_sequencer.sv
// rtl/mac_tap_sequencer.sv - job controller driving the 16x16 MAC accumulator for one N_TAPS dot product
// Purpose: on start, accepts N_TAPS operand pairs, pulses the accumulator enables
//   (bias on the first tap, running sum afterwards) and presents the finished sum.
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort input.
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-low reset
//   start          in   job request, sampled in IDLE only
//   busy           out  state is not IDLE
//   io             slave modport of mac_seq_if (s_TVALID/s_TREADY, m_TVALID/m_TREADY)
//   abort          in   (MAC_SEQ_ABORT_EN only) drop the running job
//   k_addr         out  tap index currently expected
//   acc_r1_enable  out  accumulator captures the product
//   acc_m_enable   out  accumulator adds bias (1) or running sum (0)
//   acc_enable     out  accumulator updates its sum
module mac_tap_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_TAPS = 9,
  parameter int CNT_W  = cnt_w(N_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  mac_seq_if.slave         io,
`ifdef MAC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [CNT_W-1:0] k_addr,
  output logic             acc_r1_enable,
  output logic             acc_m_enable,
  output logic             acc_enable
);

  seq_state_t       state;
  logic             pend;
  logic             first;
  logic [CNT_W-1:0] tap_cnt;
  logic             tap_last;
  logic             accept;
  logic             kill;
  logic             en_window;

`ifdef MAC_SEQ_ABORT_EN
  assign kill = abort && ((state == RUN) || (state == DRAIN));
`else
  assign kill = 1'b0;
`endif

  assign accept = (state == RUN) && io.s_TVALID && !kill;

  mac_seq_tap_ctr #(
    .N_TAPS (N_TAPS),
    .CNT_W  (CNT_W)
  ) u_tap_ctr (
    .clk   (clk),
    .reset (reset),
    .clear ((state == IDLE) || kill),
    .inc   (accept),
    .count (tap_cnt),
    .last  (tap_last)
  );

  // pend marks "a product was captured last cycle": it becomes the accumulate
  // enable one cycle after each accept, and first selects the bias for tap 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pend  <= 1'b0;
      first <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      pend  <= 1'b0;
      first <= 1'b0;
    end else begin
      pend  <= accept;
      first <= accept && (tap_cnt == '0);
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (accept && tap_last) state <= DRAIN;
        DRAIN:   state <= DONE;
        DONE:    if (io.m_TREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign en_window     = (state == RUN) || (state == DRAIN);
  assign busy          = (state != IDLE);
  assign io.s_TREADY   = (state == RUN) && !kill;
  assign io.m_TVALID   = (state == DONE);
  assign k_addr        = (state == RUN) ? tap_cnt : '0;
  assign acc_r1_enable = accept;
  assign acc_enable    = pend && en_window;
  assign acc_m_enable  = pend && first && en_window;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb/tb_mac_tap_sequencer.sv - self-checking bench for mac_tap_sequencer with a behavioural accumulator
module tb_mac_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic start3 = 1'b0, start1 = 1'b0;
  mac_seq_if bus3 ();
  mac_seq_if bus1 ();
  logic busy3, busy1;
  logic [1:0] k_addr3;
  logic [0:0] k_addr1;
  logic r1_en3, m_en3, en3, r1_en1, m_en1, en1;
`ifdef MAC_SEQ_ABORT_EN
  logic abort3 = 1'b0;
`endif

  mac_tap_sequencer #(.N_TAPS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start3),
    .busy          (busy3),
    .io            (bus3),
`ifdef MAC_SEQ_ABORT_EN
    .abort         (abort3),
`endif
    .k_addr        (k_addr3),
    .acc_r1_enable (r1_en3),
    .acc_m_enable  (m_en3),
    .acc_enable    (en3)
  );

  mac_tap_sequencer #(.N_TAPS(1)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start1),
    .busy          (busy1),
    .io            (bus1),
`ifdef MAC_SEQ_ABORT_EN
    .abort         (1'b0),
`endif
    .k_addr        (k_addr1),
    .acc_r1_enable (r1_en1),
    .acc_m_enable  (m_en1),
    .acc_enable    (en1)
  );

  // Operand source and accumulator fixtures (one accumulator per sequencer).
  logic [15:0] ivec [4];
  logic [15:0] kvec [4];
  logic [15:0] bias;
  logic [31:0] r1_3 = '0, r1_1 = '0;
  logic [39:0] sum3 = '0, sum1 = '0;

  always @(posedge clk) begin
    if (r1_en3) r1_3 <= 32'(ivec[k_addr3]) * 32'(kvec[k_addr3]);
    if (en3)    sum3 <= 40'(r1_3) + (m_en3 ? 40'(bias) : sum3);
    if (r1_en1) r1_1 <= 32'(ivec[{1'b0, k_addr1}]) * 32'(kvec[{1'b0, k_addr1}]);
    if (en1)    sum1 <= 40'(r1_1) + (m_en1 ? 40'(bias) : sum1);
  end

  // Observation mux: sel=0 watches the 3-tap sequencer, sel=1 the 1-tap one.
  logic        sel = 1'b0;
  logic        obs_busy, obs_tready, obs_mvalid, obs_r1, obs_en, obs_men;
  logic [1:0]  obs_kaddr;
  logic [39:0] obs_sum;
  always_comb begin
    if (sel) begin
      obs_busy = busy1; obs_tready = bus1.s_TREADY; obs_mvalid = bus1.m_TVALID;
      obs_r1 = r1_en1; obs_en = en1; obs_men = m_en1; obs_kaddr = {1'b0, k_addr1}; obs_sum = sum1;
    end else begin
      obs_busy = busy3; obs_tready = bus3.s_TREADY; obs_mvalid = bus3.m_TVALID;
      obs_r1 = r1_en3; obs_en = en3; obs_men = m_en3; obs_kaddr = k_addr3; obs_sum = sum3;
    end
  end

  int checks = 0;
  int failures = 0;

  // Observations collected by run_job.
  int          acc_cyc [$];
  int          mv_cyc, mv_len, r1_cnt, en_cnt, men_cnt;
  logic [39:0] mv_sum;
  bit          men_bad, done_bad, timed_out, killed;
  logic        post_busy, post_mv;

  task automatic drive(input logic st, input logic tv, input logic tr);
    if (sel) begin
      start1 = st; bus1.s_TVALID = tv; bus1.m_TREADY = tr;
      start3 = 1'b0; bus3.s_TVALID = 1'b0; bus3.m_TREADY = 1'b0;
    end else begin
      start3 = st; bus3.s_TVALID = tv; bus3.m_TREADY = tr;
      start1 = 1'b0; bus1.s_TVALID = 1'b0; bus1.m_TREADY = 1'b0;
    end
  endtask

  // Reference: bias plus the dot product over the job's taps.
  function automatic logic [39:0] model_sum(input int n);
    logic [39:0] s;
    s = 40'(bias);
    for (int t = 0; t < n; t++) s = s + 40'(ivec[t]) * 40'(kvec[t]);
    return s;
  endfunction

  task automatic randomize_job(input int n);
    bias = 16'($urandom);
    for (int t = 0; t < 4; t++) begin
      ivec[t] = (t < n) ? 16'($urandom) : 16'h0;
      kvec[t] = (t < n) ? 16'($urandom) : 16'h0;
    end
  endtask

  // Runs one job from a start pulse at cycle 0; kill_kind 0 = reset, 1 = abort.
  task automatic run_job(input int gap_min, input int gap_max, input int rdy_delay,
                         input bit start_in_done, input int kill_after, input bit kill_kind);
    int c, gap, acc_n, mv_wait;
    bit fin, kill_pending;
    logic st, tv, tr;
    acc_cyc.delete();
    mv_cyc = -1; mv_len = 0; mv_sum = '0; r1_cnt = 0; en_cnt = 0; men_cnt = 0;
    men_bad = 0; done_bad = 0; timed_out = 0; killed = 0; post_busy = 1'bx; post_mv = 1'bx;
    c = 0; gap = 0; acc_n = 0; mv_wait = 0; fin = 0; kill_pending = 0;
    while (!fin && c < 200) begin
      @(posedge clk); #1;
      if (kill_pending) begin
        drive(1'b0, 1'b0, 1'b0);
        if (kill_kind) begin
`ifdef MAC_SEQ_ABORT_EN
          abort3 = 1'b1;
`endif
        end else begin
          reset = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef MAC_SEQ_ABORT_EN
        abort3 = 1'b0;
`endif
        #1;
        killed = 1; fin = 1;
      end else begin
        st = (c == 0) || (start_in_done && obs_mvalid && mv_wait == 1);
        tv = (gap == 0);
        tr = obs_mvalid && (mv_wait >= rdy_delay);
        drive(st, tv, tr);
        #1;
        if (obs_r1) r1_cnt++;
        if (obs_en) begin
          en_cnt++;
          if (obs_men) begin
            men_cnt++;
            if (en_cnt != 1) men_bad = 1;
          end
        end else if (obs_men) begin
          men_bad = 1;
        end
        if (obs_mvalid) begin
          if (mv_cyc < 0) begin
            mv_cyc = c; mv_sum = obs_sum;
          end else if (obs_sum !== mv_sum) begin
            done_bad = 1;
          end
          if (obs_tready || obs_r1 || obs_en) done_bad = 1;
          mv_wait++;
          mv_len++;
          if (tr) fin = 1;
        end
        if (tv && obs_tready) begin
          acc_cyc.push_back(c);
          acc_n++;
          gap = $urandom_range(gap_max, gap_min);
          if (kill_after == acc_n) kill_pending = 1;
        end else if (!tv && gap > 0) begin
          gap--;
        end
        c++;
      end
    end
    timed_out = !fin;
    if (fin && !killed) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0);
      #1;
      post_busy = obs_busy; post_mv = obs_mvalid;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({obs_busy, obs_tready, obs_mvalid, obs_r1, obs_en, obs_men, obs_kaddr} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs dut_sel=%0d got=%b expected=00000000", s,
                 {obs_busy, obs_tready, obs_mvalid, obs_r1, obs_en, obs_men, obs_kaddr});
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0; bias = 16'd10;
    ivec[0] = 1; ivec[1] = 2; ivec[2] = 3; kvec[0] = 4; kvec[1] = 5; kvec[2] = 6;
    run_job(0, 0, 0, 0, 0, 0);
    checks++;
    if (timed_out || acc_cyc.size() != 3 || acc_cyc[0] != 1 || acc_cyc[1] != 2 || acc_cyc[2] != 3) begin
      failures++;
      $display("FAIL basic_accept_cycles got=%p expected='{1,2,3}", acc_cyc);
    end
    checks++;
    if (mv_cyc != 5) begin failures++; $display("FAIL basic_mvalid_cycle got=%0d expected=5", mv_cyc); end
    checks++;
    if (mv_sum !== model_sum(3) || mv_sum !== 40'd42) begin
      failures++; $display("FAIL basic_sum got=%0d expected=42", mv_sum);
    end
  endtask

  task automatic test_gaps();
    sel = 1'b0; bias = 16'd10;
    ivec[0] = 1; ivec[1] = 2; ivec[2] = 3; kvec[0] = 4; kvec[1] = 5; kvec[2] = 6;
    run_job(2, 2, 0, 0, 0, 0);
    checks++;
    if (timed_out || mv_sum !== 40'd42) begin failures++; $display("FAIL gaps_sum got=%0d expected=42", mv_sum); end
    checks++;
    if (r1_cnt != 3 || en_cnt != 3) begin
      failures++; $display("FAIL gaps_pulses got r1=%0d en=%0d expected r1=3 en=3", r1_cnt, en_cnt);
    end
    checks++;
    if (men_cnt != 1 || men_bad) begin
      failures++; $display("FAIL gaps_m_enable got count=%0d misplaced=%0d expected count=1 misplaced=0", men_cnt, men_bad);
    end
  endtask

  task automatic test_done_hold();
    sel = 1'b0; bias = 16'd10;
    ivec[0] = 1; ivec[1] = 2; ivec[2] = 3; kvec[0] = 4; kvec[1] = 5; kvec[2] = 6;
    run_job(0, 0, 4, 1, 0, 0);
    checks++;
    if (timed_out || mv_len != 5 || mv_sum !== 40'd42) begin
      failures++; $display("FAIL done_hold got len=%0d sum=%0d expected len=5 sum=42", mv_len, mv_sum);
    end
    checks++;
    if (done_bad) begin failures++; $display("FAIL done_quiet got activity=1 expected=0"); end
    checks++;
    if (post_busy !== 1'b0 || post_mv !== 1'b0) begin
      failures++; $display("FAIL done_to_idle got busy=%b mvalid=%b expected busy=0 mvalid=0", post_busy, post_mv);
    end
  endtask

  task automatic test_reset_midjob();
    sel = 1'b0; randomize_job(3);
    run_job(0, 0, 0, 0, 2, 0);
    checks++;
    if (!killed || mv_cyc >= 0 ||
        {obs_busy, obs_tready, obs_mvalid, obs_r1, obs_en, obs_men, obs_kaddr} !== 8'h00) begin
      failures++;
      $display("FAIL midjob_reset got killed=%0d outs=%b expected killed=1 outs=00000000", killed,
               {obs_busy, obs_tready, obs_mvalid, obs_r1, obs_en, obs_men, obs_kaddr});
    end
    bias = 16'd0;
    for (int t = 0; t < 3; t++) begin ivec[t] = 16'd1; kvec[t] = 16'd1; end
    run_job(0, 1, 0, 0, 0, 0);
    checks++;
    if (timed_out || mv_sum !== 40'd3) begin failures++; $display("FAIL after_reset_sum got=%0d expected=3", mv_sum); end
  endtask

  task automatic test_single_tap();
    sel = 1'b1; bias = 16'hFFFF; ivec[0] = 16'd2; kvec[0] = 16'd3;
    run_job(0, 0, 0, 0, 0, 0);
    checks++;
    if (timed_out || mv_sum !== 40'h10005) begin
      failures++; $display("FAIL single_sum got=%0h expected=10005", mv_sum);
    end
    checks++;
    if (en_cnt != 1 || men_cnt != 1 || acc_cyc.size() != 1) begin
      failures++; $display("FAIL single_pulses got en=%0d men=%0d acc=%0d expected 1 1 1", en_cnt, men_cnt, acc_cyc.size());
    end else begin
      checks++;
      if (mv_cyc - acc_cyc[0] != 2) begin
        failures++; $display("FAIL single_latency got=%0d expected=2", mv_cyc - acc_cyc[0]);
      end
    end
    sel = 1'b0;
  endtask

`ifdef MAC_SEQ_ABORT_EN
  task automatic test_abort();
    sel = 1'b0; randomize_job(3);
    run_job(0, 0, 0, 0, 1, 1);
    checks++;
    if (!killed || mv_cyc >= 0 || obs_busy !== 1'b0 || obs_mvalid !== 1'b0) begin
      failures++; $display("FAIL abort_idle got busy=%b mvalid_cycle=%0d expected busy=0 mvalid_cycle=-1", obs_busy, mv_cyc);
    end
    randomize_job(3);
    run_job(0, 2, 1, 0, 0, 0);
    checks++;
    if (timed_out || mv_sum !== model_sum(3)) begin
      failures++; $display("FAIL abort_next_job got=%0h expected=%0h", mv_sum, model_sum(3));
    end
  endtask
`endif

  task automatic test_random();
    int n;
    for (int j = 0; j < 12; j++) begin
      sel = j[0];
      n = sel ? 1 : 3;
      randomize_job(n);
      run_job(0, 3, $urandom_range(3, 0), 0, 0, 0);
      checks++;
      if (timed_out || mv_sum !== model_sum(n)) begin
        failures++; $display("FAIL random_sum job=%0d got=%0h expected=%0h", j, mv_sum, model_sum(n));
      end
      checks++;
      if (r1_cnt != n || en_cnt != n || men_cnt != 1 || men_bad || done_bad || acc_cyc.size() != n) begin
        failures++;
        $display("FAIL random_pulses job=%0d got r1=%0d en=%0d men=%0d bad=%0d/%0d expected r1=%0d en=%0d men=1 bad=0/0",
                 j, r1_cnt, en_cnt, men_cnt, men_bad, done_bad, n, n);
      end else begin
        checks++;
        if (mv_cyc - acc_cyc[n-1] != 2 || post_busy !== 1'b0) begin
          failures++; $display("FAIL random_latency job=%0d got=%0d busy_after=%b expected=2 busy_after=0",
                               j, mv_cyc - acc_cyc[n-1], post_busy);
        end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    bus3.s_TVALID = 1'b0; bus3.m_TREADY = 1'b0;
    bus1.s_TVALID = 1'b0; bus1.m_TREADY = 1'b0;
    bias = '0;
    for (int t = 0; t < 4; t++) begin ivec[t] = '0; kvec[t] = '0; end
    test_reset();
    test_basic();
    test_gaps();
    test_done_hold();
    test_reset_midjob();
    test_single_tap();
`ifdef MAC_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
